apb_master_bridge: RTL and testbench

- Single-outstanding APB3 master that turns a simple valid/ready command stream into APB setup/access transfers.
- Returns one registered response per command.
- Sits directly upstream of the team's APB RAM slave; the UVM env reuses it as the reference stimulus path.
- Adds a bounded-wait timeout so a hung or absent slave cannot stall the command source.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_master_bridge.sv | 114 +++++++++++
 tb/tb_apb_master_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default widths for the APB master bridge
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB3 master with bounded-wait timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_pclk,
  input  logic              i_preset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  // Keep the counter at least one bit wide so TIMEOUT_CYCLES=0 still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  apb_mst_state_t   state;
  logic [CNT_W-1:0] cnt;

  assign o_req_ready = (state == IDLE);

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      state         <= IDLE;
      o_psel        <= 1'b0;
      o_penable     <= 1'b0;
      o_pwrite      <= 1'b0;
      o_paddr       <= '0;
      o_pwdata      <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_err     <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_rsp_rdata   <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            o_pwrite <= i_req_write;
            o_paddr  <= i_req_addr;
            o_pwdata <= i_req_wdata;
            o_psel   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            o_rsp_rdata   <= o_pwrite ? '0 : i_prdata;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            state         <= RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            // Abort: PSEL drops here, so a late PREADY is never sampled.
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
            o_rsp_valid   <= 1'b1;
            o_psel        <= 1'b0;
            o_penable     <= 1'b0;
            state         <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          o_psel        <= 1'b0;
          o_penable     <= 1'b0;
          o_pwrite      <= 1'b0;
          o_paddr       <= '0;
          o_pwdata      <= '0;
          o_rsp_valid   <= 1'b0;
          o_rsp_err     <= 1'b0;
          o_rsp_timeout <= 1'b0;
          o_rsp_rdata   <= '0;
          cnt           <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int MODE_RAM  = 0;
  localparam int MODE_ZW   = 1;
  localparam int MODE_HANG = 2;

  logic          clk = 1'b0;
  logic          preset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_pclk(clk), .i_preset(preset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
    .o_paddr(paddr), .o_pwdata(pwdata),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  // Slave: 64-word RAM, decode error above it; PREADY registered, zero-wait, or never.
  int          mode = MODE_RAM;
  logic        ram_pready = 1'b0;
  logic [31:0] mem [64];

  assign pslverr = (paddr >= 64);
  assign prdata  = (paddr < 64) ? mem[paddr[5:0]] : '0;
  assign pready  = (mode == MODE_RAM) ? ram_pready : (mode == MODE_ZW) ? (psel && penable) : 1'b0;

  always @(posedge clk) begin
    ram_pready <= psel && penable && !ram_pready;
    if (psel && penable && pready && pwrite && (paddr < 64)) mem[paddr[5:0]] <= pwdata;
  end

  // Bus monitor: idle gap before SETUP, stable address/data while selected, ACCESS length.
  logic          prev_psel = 1'b0;
  logic          prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;
  int            proto_viol = 0;
  int            acc_len = 0;
  int            last_acc_len = 0;

  always @(negedge clk) begin
    if (psel && !penable && prev_psel) proto_viol++;
    if (psel && prev_psel && (paddr !== prev_addr || pwdata !== prev_wdata || pwrite !== prev_wr))
      proto_viol++;
    if (psel && penable) acc_len++;
    else if (acc_len != 0) begin
      last_acc_len = acc_len;
      acc_len = 0;
    end
    prev_psel  = psel;
    prev_addr  = paddr;
    prev_wdata = pwdata;
    prev_wr    = pwrite;
  end

  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] ref_mem [64];

  logic [31:0] obs_rdata;
  logic        obs_err, obs_to, obs_psel, obs_busy_ok, obs_stable, obs_after;
  int          obs_lat;
  logic [31:0] exp_rdata;
  logic        exp_err, exp_to;
  int          exp_lat;

  // Reference: what the bridge + slave must return for one command.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input int md);
    if (md == MODE_HANG) begin
      exp_rdata = 0; exp_err = 1; exp_to = 1; exp_lat = TO + 2;
    end else begin
      exp_err = (a >= 64);
      exp_to  = 0;
      if (w && !exp_err) ref_mem[a] = d;
      exp_rdata = (w || exp_err) ? 32'd0 : ref_mem[a];
      exp_lat = (md == MODE_RAM) ? 4 : 3;
    end
  endtask

  // Drive one command from a negedge; obs_lat counts accept edge to the edge that sees rsp_valid.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    int guard;
    int k;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; rsp_ready = 0;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 0;
    obs_busy_ok = 1;
    k = 1;
    while (!rsp_valid && k < 100) begin
      if (req_ready) obs_busy_ok = 0;
      @(negedge clk);
      k++;
    end
    obs_lat = k; obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout; obs_psel = psel;
    obs_stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== obs_rdata || rsp_err !== obs_err ||
          rsp_timeout !== obs_to || req_ready !== 1'b0 || psel !== 1'b0) obs_stable = 0;
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    obs_after = rsp_valid;
  endtask

  task automatic do_and_check(input string nm, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input int hold);
    model(w, a, d, mode);
    run_cmd(w, a, d, hold);
    n_vec++; if (obs_rdata !== exp_rdata) begin n_miss++; $display("FAIL %s rdata: got %h want %h", nm, obs_rdata, exp_rdata); end
    n_vec++; if (obs_err !== exp_err) begin n_miss++; $display("FAIL %s err: got %b want %b", nm, obs_err, exp_err); end
    n_vec++; if (obs_to !== exp_to) begin n_miss++; $display("FAIL %s timeout: got %b want %b", nm, obs_to, exp_to); end
    n_vec++; if (obs_lat != exp_lat) begin n_miss++; $display("FAIL %s latency: got %0d want %0d", nm, obs_lat, exp_lat); end
    n_vec++; if (obs_after !== 1'b0) begin n_miss++; $display("FAIL %s rsp_valid after handshake: got %b want 0", nm, obs_after); end
  endtask

  task automatic test_reset;
    preset = 1;
    repeat (3) @(negedge clk);
    n_vec++; if ({psel, penable, pwrite} !== 3'b000) begin n_miss++; $display("FAIL reset apb ctrl: got %b want 000", {psel, penable, pwrite}); end
    n_vec++; if (paddr !== '0 || pwdata !== '0) begin n_miss++; $display("FAIL reset addr/data: got %h/%h want 0/0", paddr, pwdata); end
    n_vec++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000 || rsp_rdata !== '0) begin n_miss++; $display("FAIL reset rsp: got %b %h want 000 0", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata); end
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    preset = 0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    mode = MODE_RAM;
    do_and_check("wr05", 1, 32'h05, 32'hDEADBEEF, 0);
    do_and_check("rd05", 0, 32'h05, 32'h0, 0);
  endtask

  task automatic test_slverr;
    mode = MODE_RAM;
    do_and_check("rd40", 0, 32'h40, 32'h0, 0);
    do_and_check("rd05_after_err", 0, 32'h05, 32'h0, 0);
    n_vec++; if (proto_viol != 0) begin n_miss++; $display("FAIL slverr bus protocol: got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_timeout;
    mode = MODE_HANG;
    do_and_check("timeout", 0, 32'h10, 32'h0, 0);
    n_vec++; if (obs_psel !== 1'b0) begin n_miss++; $display("FAIL timeout psel at rsp: got %b want 0", obs_psel); end
    n_vec++; if (last_acc_len != TO) begin n_miss++; $display("FAIL timeout access cycles: got %0d want %0d", last_acc_len, TO); end
    mode = MODE_RAM;
  endtask

  task automatic test_backpressure;
    mode = MODE_RAM;
    do_and_check("bp_rd05", 0, 32'h05, 32'h0, 5);
    n_vec++; if (obs_stable !== 1'b1) begin n_miss++; $display("FAIL backpressure hold: got %b want 1", obs_stable); end
    n_vec++; if (obs_busy_ok !== 1'b1) begin n_miss++; $display("FAIL backpressure req_ready busy: got %b want 1", obs_busy_ok); end
    do_and_check("bp_next", 1, 32'h06, 32'h0BADF00D, 0);
    n_vec++; if (proto_viol != 0) begin n_miss++; $display("FAIL backpressure bus protocol: got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_reset_mid;
    int guard;
    mode = MODE_HANG;
    req_valid = 1; req_write = 0; req_addr = 32'h03;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    n_vec++; if ({psel, penable} !== 2'b11) begin n_miss++; $display("FAIL resetmid in access: got %b want 11", {psel, penable}); end
    preset = 1;
    @(negedge clk);
    preset = 0;
    n_vec++; if ({psel, penable, rsp_valid, req_ready} !== 4'b0001) begin n_miss++; $display("FAIL resetmid outputs: got %b want 0001", {psel, penable, rsp_valid, req_ready}); end
    mode = MODE_RAM;
    do_and_check("wr01_after_reset", 1, 32'h01, 32'h12345678, 0);
    do_and_check("rd01_after_reset", 0, 32'h01, 32'h0, 0);
  endtask

  task automatic test_back_to_back;
    mode = MODE_RAM;
    for (int i = 0; i < 8; i++) do_and_check("b2b_wr", 1, i, i * 32'h11, 0);
    for (int i = 0; i < 8; i++) do_and_check("b2b_rd", 0, i, 32'h0, 0);
    n_vec++; if (proto_viol != 0) begin n_miss++; $display("FAIL b2b bus protocol: got %0d violations want 0", proto_viol); end
  endtask

  task automatic test_random;
    int r;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      mode = (r == 0) ? MODE_HANG : (r % 2);
      do_and_check("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 79), $urandom, $urandom_range(0, 3));
    end
    mode = MODE_RAM;
    n_vec++; if (proto_viol != 0) begin n_miss++; $display("FAIL random bus protocol: got %0d violations want 0", proto_viol); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    @(negedge clk);
    test_reset;
    test_write_read;
    test_slverr;
    test_timeout;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
